// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle between N producers, the stream_mux_rr arbiter and one consumer.
// Optional packet framing (in_last/out_last) exists when STREAM_MUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                       mode;
  logic [CH_W-1:0]            sel_ch;
  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH*DATA_W-1:0]   in_data;
  logic [NUM_CH-1:0]          in_ready;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic [CH_W-1:0]            out_ch;
  logic                       out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [NUM_CH-1:0]          in_last;
  logic                       out_last;

  modport master (
    output mode, sel_ch, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
  modport slave (
    input  mode, sel_ch, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
`else
  modport master (
    output mode, sel_ch, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input  mode, sel_ch, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux (round-robin or fixed select) with a 1-entry output register.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_mux_rr_if.slave       bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q,  out_data_d;
  logic [CH_W-1:0]       out_ch_q,    out_ch_d;
  logic [CH_W-1:0]       rr_ptr_q,    rr_ptr_d;

  logic [CH_W-1:0]       arb_ch;
  logic                  arb_valid;
  logic [CH_W-1:0]       grant_ch;
  logic                  grant_valid;
  logic                  load;
  logic                  xfer;
  logic                  advance;
  logic [DATA_W-1:0]     grant_data;
  logic [NUM_CH-1:0]     in_ready_c;

  // Free arbitration: fixed select, or first valid channel at or after rr_ptr.
  always_comb begin
    arb_ch    = {CH_W{1'b0}};
    arb_valid = 1'b0;
    if (bus.mode == 1'b1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        arb_ch    = (bus.sel_ch == CH_W'(i)) ? CH_W'(i) : arb_ch;
        arb_valid = (bus.sel_ch == CH_W'(i)) ? bus.in_valid[i] : arb_valid;
      end
    end else begin
      // Walk farthest-to-nearest so the nearest valid channel is written last and wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if ((((int'(rr_ptr_q) + k) % NUM_CH) == i) && bus.in_valid[i]) begin
            arb_ch    = CH_W'(i);
            arb_valid = 1'b1;
          end else begin
            arb_valid = arb_valid;
          end
        end
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic [CH_W-1:0]       lock_ch_q,  lock_ch_d;
  logic                  out_last_q, out_last_d;
  logic                  grant_last;

  assign grant_ch    = (state_q == ST_LOCKED) ? lock_ch_q : arb_ch;
  assign grant_valid = (state_q == ST_LOCKED) ? bus.in_valid[lock_ch_q] : arb_valid;
  assign bus.out_last = out_last_q;

  // Packet lock FSM: a non-last beat opens a lock, the last beat of that channel closes it.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && !grant_last) begin
          state_d   = ST_LOCKED;
          lock_ch_d = grant_ch;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer && grant_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign advance = xfer && grant_last;
`else
  logic                  grant_last;

  assign grant_ch    = arb_ch;
  assign grant_valid = arb_valid;
  assign advance     = xfer;
`endif

  assign load = rst_n && (!out_valid_q || bus.out_ready);
  assign xfer = load && grant_valid;

  // Mux the granted channel's data (and last flag) and decode the one-hot ready.
  always_comb begin
    grant_data = {DATA_W{1'b0}};
    grant_last = 1'b0;
    in_ready_c = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      grant_data    = (grant_ch == CH_W'(i)) ? bus.in_data[i*DATA_W +: DATA_W] : grant_data;
`ifdef STREAM_MUX_PKT_LOCK_EN
      grant_last    = (grant_ch == CH_W'(i)) ? bus.in_last[i] : grant_last;
`endif
      in_ready_c[i] = xfer && (grant_ch == CH_W'(i));
    end
  end

  // Output register next-state and round-robin pointer update.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last_d  = grant_last;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (advance && (bus.mode == 1'b0)) begin
      rr_ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : grant_ch + CH_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_ch_q    <= {CH_W{1'b0}};
      rr_ptr_q    <= {CH_W{1'b0}};
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last_q  <= 1'b0;
      state_q     <= ST_IDLE;
      lock_ch_q   <= {CH_W{1'b0}};
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last_q  <= out_last_d;
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed vector table, packet-lock sequence (when enabled),
// and randomized traffic against a queue-free behavioural model of the mux rules.
module tb_stream_mux_rr;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     t_mode;
  logic [CH_W-1:0]          t_sel;
  logic [NUM_CH-1:0]        t_iv;
  logic [NUM_CH*DATA_W-1:0] t_data;
  logic [NUM_CH-1:0]        t_last;
  logic                     t_ordy;

  stream_mux_rr_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();
  stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign bus.mode      = t_mode;
  assign bus.sel_ch    = t_sel;
  assign bus.in_valid  = t_iv;
  assign bus.in_data   = t_data;
  assign bus.out_ready = t_ordy;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign bus.in_last   = t_last;
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int   m_rr;
  bit   m_ov;
  int   m_ch;
  logic [DATA_W-1:0] m_data;
  bit   m_last;
  bit   m_locked;
  int   m_lock_ch;

  typedef struct {
    bit              mode;
    logic [CH_W-1:0] sel;
    logic [3:0]      iv;
    bit              ordy;
    logic [3:0]      exp_rdy;
    bit              exp_ov;
    logic [CH_W-1:0] exp_ch;
    logic [7:0]      exp_data;
  } vec_t;
  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_default_data();
    for (int i = 0; i < NUM_CH; i++) t_data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_ordy = 1'b0;
    @(posedge clk); #1;
    chk("midreset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midreset out_ch", {30'd0, bus.out_ch}, 32'd0);
    rst_n = 1'b1;
    m_rr = 0; m_ov = 1'b0; m_ch = 0; m_data = '0; m_last = 1'b0;
    m_locked = 1'b0; m_lock_ch = 0;
  endtask

  function automatic int model_grant();
    if (m_locked) return t_iv[m_lock_ch] ? m_lock_ch : -1;
    if (t_mode) return (int'(t_sel) < NUM_CH && t_iv[t_sel]) ? int'(t_sel) : -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (t_iv[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle(input string tag);
    int g;
    bit load;
    bit lst;
    logic [NUM_CH-1:0] exp_rdy;
    g = model_grant();
    load = !m_ov || t_ordy;
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    #4;
    chk({tag, " in_ready"}, {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (load && g >= 0) begin
      lst = LOCK_EN ? t_last[g] : 1'b1;
      m_ov = 1'b1; m_ch = g; m_data = t_data[g*DATA_W +: DATA_W]; m_last = t_last[g];
      if (!m_locked && !lst) begin
        m_locked = 1'b1; m_lock_ch = g;
      end else if (lst) begin
        m_locked = 1'b0;
        if (!t_mode) m_rr = (g + 1) % NUM_CH;
      end
    end else if (t_ordy) begin
      m_ov = 1'b0;
    end
    #1;
    chk({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk({tag, " out_ch"}, {30'd0, bus.out_ch}, 32'(m_ch));
      chk({tag, " out_data"}, {24'd0, bus.out_data}, {24'd0, m_data});
`ifdef STREAM_MUX_PKT_LOCK_EN
      chk({tag, " out_last"}, {31'd0, bus.out_last}, {31'd0, m_last});
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    t_mode = 1'b0; t_sel = 2'd0; t_iv = 4'b1111; t_ordy = 1'b1; t_last = 4'b1111;
    set_default_data();

    // Reset held two cycles with all channels valid
    @(posedge clk); #1;
    chk("reset in_ready c1", {28'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("reset in_ready c2", {28'd0, bus.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset out_ch", {30'd0, bus.out_ch}, 32'd0);
    chk("reset out_data", {24'd0, bus.out_data}, 32'd0);
    rst_n = 1'b1;

    // mode sel iv ordy | exp_rdy ov ch data
    vecs[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[1]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    vecs[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    vecs[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[5]  = '{1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    vecs[6]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    vecs[7]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    vecs[8]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
    vecs[9]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
    vecs[10] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
    vecs[11] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    vecs[12] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
    vecs[13] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'hA2};
    vecs[14] = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    vecs[15] = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    vecs[16] = '{1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
    vecs[17] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3};
    vecs[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};

    for (int v = 0; v < 20; v++) begin
      t_mode = vecs[v].mode; t_sel = vecs[v].sel; t_iv = vecs[v].iv; t_ordy = vecs[v].ordy;
      #4;
      chk($sformatf("vec%0d in_ready", v), {28'd0, bus.in_ready}, {28'd0, vecs[v].exp_rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", v), {31'd0, bus.out_valid}, {31'd0, vecs[v].exp_ov});
      chk($sformatf("vec%0d out_ch", v), {30'd0, bus.out_ch}, {30'd0, vecs[v].exp_ch});
      chk($sformatf("vec%0d out_data", v), {24'd0, bus.out_data}, {24'd0, vecs[v].exp_data});
    end

    // Reset while a beat is held drops it
    do_reset();

`ifdef STREAM_MUX_PKT_LOCK_EN
    begin
      logic       pm [4];
      logic [1:0] ps [4];
      logic [3:0] piv [4];
      logic [3:0] plast [4];
      logic [3:0] prdy [4];
      logic [1:0] pch [4];
      logic       plst [4];
      pm = '{1'b0, 1'b1, 1'b0, 1'b0};
      ps = '{2'd0, 2'd1, 2'd0, 2'd0};
      piv = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
      plast = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
      prdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      pch = '{2'd0, 2'd0, 2'd0, 2'd1};
      plst = '{1'b0, 1'b0, 1'b1, 1'b0};
      t_ordy = 1'b1;
      for (int p = 0; p < 4; p++) begin
        t_mode = pm[p]; t_sel = ps[p]; t_iv = piv[p]; t_last = plast[p];
        #4;
        chk($sformatf("pkt%0d in_ready", p), {28'd0, bus.in_ready}, {28'd0, prdy[p]});
        @(posedge clk); #1;
        chk($sformatf("pkt%0d out_ch", p), {30'd0, bus.out_ch}, {30'd0, pch[p]});
        chk($sformatf("pkt%0d out_last", p), {31'd0, bus.out_last}, {31'd0, plst[p]});
      end
      do_reset();
    end
`endif

    // Randomized traffic against the behavioural model
    for (int n = 0; n < 400; n++) begin
      t_mode = ($urandom_range(0, 3) == 0);
      t_sel  = CH_W'($urandom_range(0, NUM_CH - 1));
      t_iv   = NUM_CH'($urandom);
      t_ordy = ($urandom_range(0, 3) != 0);
      t_data = NUM_CH*DATA_W'($urandom);
      t_last = NUM_CH'($urandom);
      model_cycle($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
